// File: rtl/freq_sched_pkg.sv
// Shared types and constants for the frequency-measurement scheduler.
package freq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam int PERIOD_W = 21;
  localparam int SAMPLE_W = 16;
  localparam logic [PERIOD_W-1:0] TIMEOUT_VAL = 21'h1FFFFF;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) begin
        lowest_set = 4'(i);
      end
    end
  endfunction

endpackage

// File: rtl/freq_meas_scheduler_next_ch_sel.sv
// Channel picker: next enabled channel above the current one, and the first enabled channel.
module next_ch_sel
  import freq_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [3:0]        cur_ch,
  output logic [3:0]        nxt_ch,
  output logic              found,
  output logic [3:0]        first_ch
);

  // Scan downward so the lowest qualifying channel is the last one written.
  always_comb begin
    nxt_ch = 4'd0;
    found  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) > cur_ch)) begin
        nxt_ch = 4'(i);
        found  = 1'b1;
      end else begin
        nxt_ch = nxt_ch;
        found  = found;
      end
    end
  end

  assign first_ch = lowest_set(16'(mask));

endmodule

// File: rtl/freq_meas_scheduler.sv
// Time-multiplexes one zero-crossing frequency calculator over NUM_CH band channels,
// capturing one period count (or a timeout) per enabled channel per sweep.
module freq_meas_scheduler
  import freq_sched_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 21'h1FFFFF,
  parameter int DISCARD     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cont,
  input  logic                       abort,
  input  logic [NUM_CH-1:0]          en_mask,
  input  logic [SAMPLE_W*NUM_CH-1:0] ch_sample,
  input  logic                       ch_sample_vld,
  output logic                       calc_clr,
  output logic [SAMPLE_W-1:0]        calc_sample,
  output logic                       calc_sample_vld,
  input  logic                       calc_cnt_vld,
  input  logic [PERIOD_W-1:0]        calc_cnt,
  output logic                       result_vld,
  output logic [3:0]                 result_ch,
  output logic [PERIOD_W-1:0]        result_period,
  output logic                       result_timeout,
  output logic                       busy,
  output logic                       sweep_done
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_LAST = PERIOD_W'(TIMEOUT_CYC - 1);

  state_t                state_q;
  logic [NUM_CH-1:0]     mask_q;
  logic [3:0]            cur_ch_q;
  logic [1:0]            disc_cnt_q;
  logic [PERIOD_W-1:0]   timer_q;
  logic                  calc_clr_q;
  logic [SAMPLE_W-1:0]   calc_sample_q;
  logic                  calc_sample_vld_q;
  logic                  result_vld_q;
  logic [3:0]            result_ch_q;
  logic [PERIOD_W-1:0]   result_period_q;
  logic                  result_timeout_q;
  logic                  busy_q;
  logic                  sweep_done_q;

  logic [NUM_CH-1:0]     sel_mask_s;
  logic [3:0]            nxt_ch_s;
  logic                  found_s;
  logic [3:0]            first_ch_s;
  logic [3:0]            relatch_ch_s;
  logic [PERIOD_W-1:0]   timer_d;
  logic                  cnt_accept_s;
  logic                  timeout_hit_s;
  logic                  leave_meas_s;
  logic                  sample_vld_d;
  logic [SAMPLE_W-1:0]   samp_arr [16];

  for (genvar g = 0; g < 16; g++) begin : g_samp
    if (g < NUM_CH) begin : g_used
      assign samp_arr[g] = ch_sample[g*SAMPLE_W +: SAMPLE_W];
    end else begin : g_pad
      assign samp_arr[g] = 16'd0;
    end
  end

  // In IDLE the picker looks at the live enable mask to choose the first channel.
  assign sel_mask_s = (state_q == IDLE) ? en_mask : mask_q;

  next_ch_sel #(.NUM_CH(NUM_CH)) u_next_ch_sel (
    .mask     (sel_mask_s),
    .cur_ch   (cur_ch_q),
    .nxt_ch   (nxt_ch_s),
    .found    (found_s),
    .first_ch (first_ch_s)
  );

  assign relatch_ch_s  = lowest_set(16'(en_mask));
  assign timer_d       = timer_q + 21'd1;
  assign cnt_accept_s  = (state_q == MEASURE) && calc_cnt_vld && (disc_cnt_q == 2'd0);
  assign timeout_hit_s = (state_q == MEASURE) && !cnt_accept_s && (timer_d == TIMEOUT_LAST);
  assign leave_meas_s  = cnt_accept_s || timeout_hit_s;
  // A strobe landing on the cycle MEASURE is left is dropped, not forwarded.
  assign sample_vld_d  = (state_q == MEASURE) && ch_sample_vld && !leave_meas_s && !abort;

  // Sweep sequencer with registered calculator and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      mask_q            <= '0;
      cur_ch_q          <= 4'd0;
      disc_cnt_q        <= 2'd0;
      timer_q           <= 21'd0;
      calc_clr_q        <= 1'b0;
      calc_sample_q     <= 16'd0;
      calc_sample_vld_q <= 1'b0;
      result_vld_q      <= 1'b0;
      result_ch_q       <= 4'd0;
      result_period_q   <= 21'd0;
      result_timeout_q  <= 1'b0;
      busy_q            <= 1'b0;
      sweep_done_q      <= 1'b0;
    end else begin
      calc_clr_q        <= 1'b0;
      result_vld_q      <= 1'b0;
      sweep_done_q      <= 1'b0;
      calc_sample_vld_q <= sample_vld_d;
      if (sample_vld_d) begin
        calc_sample_q <= samp_arr[cur_ch_q];
      end
      if (abort && (state_q != IDLE)) begin
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        calc_clr_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if ((start || cont) && (en_mask != '0)) begin
              mask_q     <= en_mask;
              cur_ch_q   <= first_ch_s;
              state_q    <= CLEAR;
              calc_clr_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
          CLEAR: begin
            disc_cnt_q <= 2'(DISCARD);
            timer_q    <= 21'd0;
            state_q    <= MEASURE;
          end
          MEASURE: begin
            timer_q <= timer_d;
            if (calc_cnt_vld && (disc_cnt_q != 2'd0)) begin
              disc_cnt_q <= disc_cnt_q - 2'd1;
            end
            if (leave_meas_s) begin
              state_q          <= REPORT;
              result_vld_q     <= 1'b1;
              result_ch_q      <= cur_ch_q;
              result_period_q  <= cnt_accept_s ? calc_cnt : TIMEOUT_VAL;
              result_timeout_q <= !cnt_accept_s;
              sweep_done_q     <= !found_s;
            end
          end
          REPORT: begin
            if (found_s) begin
              cur_ch_q   <= nxt_ch_s;
              state_q    <= CLEAR;
              calc_clr_q <= 1'b1;
            end else if (cont && (en_mask != '0)) begin
              mask_q     <= en_mask;
              cur_ch_q   <= relatch_ch_s;
              state_q    <= CLEAR;
              calc_clr_q <= 1'b1;
            end else begin
              if (cont) begin
                mask_q <= en_mask;
              end
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign calc_clr        = calc_clr_q;
  assign calc_sample     = calc_sample_q;
  assign calc_sample_vld = calc_sample_vld_q;
  assign result_vld      = result_vld_q;
  assign result_ch       = result_ch_q;
  assign result_period   = result_period_q;
  assign result_timeout  = result_timeout_q;
  assign busy            = busy_q;
  assign sweep_done      = sweep_done_q;

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Self-checking bench for freq_meas_scheduler; the calculator is emulated by driving count strobes.
module tb_freq_meas_scheduler;

  localparam int NCH = 4;
  localparam int TMO = 5000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cont;
  logic          abort;
  logic [3:0]    en_mask;
  logic [63:0]   ch_sample;
  logic          ch_sample_vld;
  logic          calc_clr;
  logic [15:0]   calc_sample;
  logic          calc_sample_vld;
  logic          calc_cnt_vld;
  logic [20:0]   calc_cnt;
  logic          result_vld;
  logic [3:0]    result_ch;
  logic [20:0]   result_period;
  logic          result_timeout;
  logic          busy;
  logic          sweep_done;

  int checks = 0;
  int errors = 0;

  freq_meas_scheduler #(.NUM_CH(NCH), .TIMEOUT_CYC(TMO), .DISCARD(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cont            (cont),
    .abort           (abort),
    .en_mask         (en_mask),
    .ch_sample       (ch_sample),
    .ch_sample_vld   (ch_sample_vld),
    .calc_clr        (calc_clr),
    .calc_sample     (calc_sample),
    .calc_sample_vld (calc_sample_vld),
    .calc_cnt_vld    (calc_cnt_vld),
    .calc_cnt        (calc_cnt),
    .result_vld      (result_vld),
    .result_ch       (result_ch),
    .result_period   (result_period),
    .result_timeout  (result_timeout),
    .busy            (busy),
    .sweep_done      (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [49:0] outs;
    rst = 1'b1;
    repeat (3) tick;
    outs = {calc_clr, calc_sample, calc_sample_vld, result_vld, result_ch,
            result_period, result_timeout, busy, sweep_done};
    checks++;
    if (outs !== 50'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", outs);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || calc_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy %b clr %b exp 0 0", busy, calc_clr);
    end
  endtask

  // Launch a sweep from IDLE; returns in the CLEAR cycle.
  task automatic start_sweep(input logic [3:0] m);
    en_mask = m;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    checks++;
    if (calc_clr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_clear clr %b busy %b exp 1 1", calc_clr, busy);
    end
  endtask

  // Called in a CLEAR cycle: feed one discarded and one accepted count, check the report.
  task automatic check_channel(input int exp_ch, input bit exp_last, input bit exp_next_clear);
    logic [20:0] v;
    v = 21'($urandom_range(100, 2000000));
    tick;
    repeat ($urandom_range(0, 5)) tick;
    calc_cnt_vld = 1'b1;
    calc_cnt     = 21'($urandom);
    tick;
    calc_cnt_vld = 1'b0;
    checks++;
    if (result_vld !== 1'b0) begin
      errors++;
      $display("FAIL discard_first ch %0d result_vld %b exp 0", exp_ch, result_vld);
    end
    repeat ($urandom_range(0, 5)) tick;
    calc_cnt_vld = 1'b1;
    calc_cnt     = v;
    tick;
    calc_cnt_vld = 1'b0;
    checks++;
    if (result_vld !== 1'b1 || result_ch !== 4'(exp_ch) || result_period !== v ||
        result_timeout !== 1'b0 || sweep_done !== exp_last) begin
      errors++;
      $display("FAIL report ch got vld %b ch %0d per %0d to %b done %b exp 1 %0d %0d 0 %b",
               result_vld, result_ch, result_period, result_timeout, sweep_done,
               exp_ch, v, exp_last);
    end
    tick;
    checks++;
    if (calc_clr !== exp_next_clear || busy !== exp_next_clear || result_vld !== 1'b0 ||
        result_period !== v) begin
      errors++;
      $display("FAIL after_report clr %b busy %b vld %b per %0d exp %b %b 0 %0d",
               calc_clr, busy, result_vld, result_period, exp_next_clear, exp_next_clear, v);
    end
  endtask

  // Reference order: enabled channels ascending, one result each.
  task automatic sweep_body(input logic [3:0] m, input bit relaunch);
    int chs[$];
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) chs.push_back(i);
    end
    foreach (chs[k]) begin
      check_channel(chs[k], k == chs.size() - 1, (k != chs.size() - 1) || relaunch);
    end
  endtask

  task automatic test_single;
    start_sweep(4'b0001);
    sweep_body(4'b0001, 1'b0);
  endtask

  task automatic test_two_ch;
    start_sweep(4'b0101);
    sweep_body(4'b0101, 1'b0);
  endtask

  task automatic test_forward;
    logic [15:0] v;
    ch_sample = {$urandom, $urandom};
    start_sweep(4'b0100);
    ch_sample_vld = 1'b1;
    tick;
    ch_sample_vld = 1'b0;
    checks++;
    if (calc_sample_vld !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_fwd vld %b exp 0", calc_sample_vld);
    end
    for (int k = 0; k < 6; k++) begin
      v = 16'($urandom);
      ch_sample = {$urandom, $urandom};
      ch_sample[32 +: 16] = v;
      ch_sample_vld = 1'b1;
      tick;
      ch_sample_vld = 1'b0;
      ch_sample = {$urandom, $urandom};
      checks++;
      if (calc_sample_vld !== 1'b1 || calc_sample !== v) begin
        errors++;
        $display("FAIL fwd_sample vld %b data %h exp 1 %h", calc_sample_vld, calc_sample, v);
      end
      tick;
      checks++;
      if (calc_sample_vld !== 1'b0 || calc_sample !== v) begin
        errors++;
        $display("FAIL fwd_hold vld %b data %h exp 0 %h", calc_sample_vld, calc_sample, v);
      end
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    int  m;
    bit  strb;
    bit  exp_vld;
    bit  done;
    ch_sample = {$urandom, $urandom};
    ch_sample[16 +: 16] = 16'd32868;
    start_sweep(4'b0010);
    m    = 0;
    done = 1'b0;
    while (!done) begin
      ch_sample_vld = ((m % 10) == 9);
      strb = ch_sample_vld;
      tick;
      m++;
      ch_sample_vld = 1'b0;
      exp_vld = strb && (m >= 2) && (m <= TMO - 1);
      checks++;
      if (calc_sample_vld !== exp_vld || (exp_vld && calc_sample !== 16'd32868)) begin
        errors++;
        $display("FAIL tmo_fwd cyc %0d vld %b data %h exp %b 8064", m, calc_sample_vld,
                 calc_sample, exp_vld);
      end
      if (result_vld === 1'b1 || m >= TMO + 100) done = 1'b1;
    end
    checks++;
    if (m != TMO || result_vld !== 1'b1 || result_timeout !== 1'b1 ||
        result_period !== 21'h1FFFFF || result_ch !== 4'd1 || sweep_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout cyc %0d vld %b to %b per %h ch %0d done %b exp %0d 1 1 1fffff 1 1",
               m, result_vld, result_timeout, result_period, result_ch, sweep_done, TMO);
    end
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle busy %b exp 0", busy);
    end
  endtask

  task automatic test_cont;
    cont = 1'b1;
    start_sweep(4'b0011);
    sweep_body(4'b0011, 1'b1);
    cont    = 1'b0;
    en_mask = 4'b1100;
    sweep_body(4'b0011, 1'b0);
    repeat (3) tick;
    checks++;
    if (busy !== 1'b0 || result_vld !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop busy %b vld %b exp 0 0", busy, result_vld);
    end
    en_mask = 4'b0000;
  endtask

  task automatic test_abort;
    start_sweep(4'b0100);
    repeat (3) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || calc_clr !== 1'b1 || result_vld !== 1'b0 || sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL abort busy %b clr %b vld %b done %b exp 0 1 0 0", busy, calc_clr,
               result_vld, sweep_done);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || calc_clr !== 1'b0 || result_vld !== 1'b0) begin
      errors++;
      $display("FAIL abort_after busy %b clr %b vld %b exp 0 0 0", busy, calc_clr, result_vld);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || calc_clr !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle busy %b clr %b exp 0 0", busy, calc_clr);
    end
    start_sweep(4'b0100);
    sweep_body(4'b0100, 1'b0);
  endtask

  task automatic test_rst_mid;
    logic [49:0] outs;
    start_sweep(4'b0001);
    repeat (2) tick;
    calc_cnt_vld = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    calc_cnt_vld = 1'b0;
    outs = {calc_clr, calc_sample, calc_sample_vld, result_vld, result_ch,
            result_period, result_timeout, busy, sweep_done};
    checks++;
    if (outs !== 50'd0) begin
      errors++;
      $display("FAIL rst_mid got %h exp 0", outs);
    end
    en_mask = 4'b0000;
    start   = 1'b1;
    tick;
    start   = 1'b0;
    checks++;
    if (busy !== 1'b0 || calc_clr !== 1'b0) begin
      errors++;
      $display("FAIL zero_mask busy %b clr %b exp 0 0", busy, calc_clr);
    end
  endtask

  task automatic test_random_sweeps;
    logic [3:0] m;
    for (int it = 0; it < 6; it++) begin
      m = 4'($urandom_range(1, 15));
      start_sweep(m);
      sweep_body(m, 1'b0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    cont          = 1'b0;
    abort         = 1'b0;
    en_mask       = 4'b0000;
    ch_sample     = 64'd0;
    ch_sample_vld = 1'b0;
    calc_cnt_vld  = 1'b0;
    calc_cnt      = 21'd0;
    test_reset;
    test_single;
    test_two_ch;
    test_forward;
    test_timeout;
    test_cont;
    test_abort;
    test_rst_mid;
    test_random_sweeps;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
